// File: rtl/ecc_sed_pkg.sv
// ecc_sed_pkg: shared definitions for the single-error-detect (SED) parity
// encoder/decoder pair.
//   DATA_W / CW_W   : default data and codeword widths (codeword = {parity, data})
//   ODD_PARITY_DEF  : default parity polarity (1 = valid codewords have odd weight)
//   cw_parity()     : XOR reduction of a codeword, zero-extended to PAR_MAX_W bits
package ecc_sed_pkg;

    localparam int DATA_W    = 12;
    localparam int CW_W      = DATA_W + 1;
    localparam bit ODD_PARITY_DEF = 1'b1;

    // Upper bound on codeword width accepted by cw_parity; callers zero-extend,
    // which leaves the XOR reduction unchanged.
    localparam int PAR_MAX_W = 64;

    function automatic logic cw_parity(input logic [PAR_MAX_W-1:0] cw);
        return ^cw;
    endfunction

endpackage

// File: rtl/ecc_sed_err_cnt.sv
// ecc_sed_err_cnt: saturating error counter with sticky flag.
//   clk        : clock, rising edge
//   rst        : asynchronous reset, active low
//   err_inc    : an erroneous word is being accepted this cycle
//   err_clr    : synchronous clear; wins over a same-cycle err_inc
//   err_sticky : set by any counted error, held until err_clr
//   err_count  : number of counted errors, saturates at all-ones
module ecc_sed_err_cnt
    import ecc_sed_pkg::*;
#(
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 err_inc,
    input  logic                 err_clr,
    output logic                 err_sticky,
    output logic [ERR_CNT_W-1:0] err_count
);

    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    // Status stage: updates alongside the output register load
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_sticky <= 1'b0;
            err_count  <= '0;
        end else if (err_clr) begin
            err_sticky <= 1'b0;
            err_count  <= '0;
        end else if (err_inc) begin
            err_sticky <= 1'b1;
            err_count  <= sat_inc(err_count);
        end
    end

endmodule

// File: rtl/ecc_sed_decoder.sv
// ecc_sed_decoder: checks parity on {parity, data} codewords, strips the parity
// bit and presents the data word through a registered valid/ready stage.
// Optional build macro: ECC_SED_DROP_EN -- erroneous words are counted but
// never presented on the output (dec_err is then constant 0).
//   clk          : clock, rising edge
//   rst          : asynchronous reset, active low
//   enc_valid    : codeword present
//   enc_ready    : decoder can accept a codeword this cycle
//   enc_codeword : {parity, data[DATA_W-1:0]}
//   dec_valid    : decoded word held in the output register
//   dec_ready    : consumer takes the output this cycle
//   dec_data     : decoded data word
//   dec_err      : parity error on the presented word (qualified by dec_valid)
//   err_sticky   : set by any accepted erroneous word
//   err_count    : saturating count of accepted erroneous words
//   err_clr      : synchronous clear of err_sticky/err_count
module ecc_sed_decoder
    import ecc_sed_pkg::*;
#(
    parameter int DATA_W     = ecc_sed_pkg::DATA_W,
    parameter bit ODD_PARITY = ecc_sed_pkg::ODD_PARITY_DEF,
    parameter int ERR_CNT_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enc_valid,
    output logic                 enc_ready,
    input  logic [DATA_W:0]      enc_codeword,
    output logic                 dec_valid,
    input  logic                 dec_ready,
    output logic [DATA_W-1:0]    dec_data,
    output logic                 dec_err,
    output logic                 err_sticky,
    output logic [ERR_CNT_W-1:0] err_count,
    input  logic                 err_clr
);

    logic [PAR_MAX_W-1:0] cw_ext;
    logic                 par_p0;
    logic                 err_p0;
    logic                 acc_p0;
    logic                 err_inc_p0;

    logic                 vld_p1;
    logic [DATA_W-1:0]    data_p1;

    // Input stage: combinational parity check and handshake
    assign cw_ext     = PAR_MAX_W'(enc_codeword);
    assign par_p0     = cw_parity(cw_ext);
    assign err_p0     = ODD_PARITY ? !par_p0 : par_p0;

    assign enc_ready  = !vld_p1 || dec_ready;
    assign acc_p0     = enc_valid && enc_ready;
    // acc_p0 is evaluated first so an X codeword with enc_valid low stays out
    assign err_inc_p0 = acc_p0 && err_p0;

`ifdef ECC_SED_DROP_EN
    logic load_p0;
    assign load_p0 = acc_p0 && !err_p0;

    // Output stage: only clean words are loaded
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
        end else if (load_p0) begin
            vld_p1  <= 1'b1;
            data_p1 <= enc_codeword[DATA_W-1:0];
        end else if (dec_ready) begin
            vld_p1  <= 1'b0;
        end
    end

    assign dec_err = 1'b0;
`else
    logic err_p1;

    // Output stage: every accepted word is loaded with its error flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
            err_p1  <= 1'b0;
        end else if (acc_p0) begin
            vld_p1  <= 1'b1;
            data_p1 <= enc_codeword[DATA_W-1:0];
            err_p1  <= err_p0;
        end else if (dec_ready) begin
            vld_p1  <= 1'b0;
        end
    end

    assign dec_err = err_p1;
`endif

    assign dec_valid = vld_p1;
    assign dec_data  = data_p1;

    ecc_sed_err_cnt #(
        .ERR_CNT_W (ERR_CNT_W)
    ) u_err_cnt (
        .clk        (clk),
        .rst        (rst),
        .err_inc    (err_inc_p0),
        .err_clr    (err_clr),
        .err_sticky (err_sticky),
        .err_count  (err_count)
    );

endmodule

// File: tb/tb_ecc_sed_decoder.sv
// tb_ecc_sed_decoder: directed bench for ecc_sed_decoder (DATA_W=12,
// ODD_PARITY=1, ERR_CNT_W=8). Inputs change 1 time unit after the rising
// edge; outputs are sampled there as well, away from the edge.
module tb_ecc_sed_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        enc_valid;
    logic        enc_ready;
    logic [12:0] enc_codeword;
    logic        dec_valid;
    logic        dec_ready;
    logic [11:0] dec_data;
    logic        dec_err;
    logic        err_sticky;
    logic [7:0]  err_count;
    logic        err_clr;

    int vectors = 0;
    int miscompares = 0;

    ecc_sed_decoder #(
        .DATA_W     (12),
        .ODD_PARITY (1'b1),
        .ERR_CNT_W  (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enc_valid    (enc_valid),
        .enc_ready    (enc_ready),
        .enc_codeword (enc_codeword),
        .dec_valid    (dec_valid),
        .dec_ready    (dec_ready),
        .dec_data     (dec_data),
        .dec_err      (dec_err),
        .err_sticky   (err_sticky),
        .err_count    (err_count),
        .err_clr      (err_clr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst          = 1'b0;
        enc_valid    = 1'b0;
        enc_codeword = '0;
        dec_ready    = 1'b1;
        err_clr      = 1'b0;
        tick();
        tick();
        chk("rst_valid",  32'(dec_valid),  32'h0);
        chk("rst_data",   32'(dec_data),   32'h0);
        chk("rst_err",    32'(dec_err),    32'h0);
        chk("rst_sticky", 32'(err_sticky), 32'h0);
        chk("rst_count",  32'(err_count),  32'h0);
        rst = 1'b1;
        tick();

`ifdef ECC_SED_DROP_EN
        begin
            int xfers;
            xfers = 0;
            enc_valid = 1'b1; enc_codeword = 13'h1000;
            tick();
            chk("drop_v0", 32'(dec_valid), 32'h1);
            chk("drop_d0", 32'(dec_data),  32'h000);
            if (dec_valid) xfers++;
            enc_codeword = 13'h0000;
            tick();
            chk("drop_v1",   32'(dec_valid), 32'h0);
            chk("drop_cnt1", 32'(err_count), 32'h1);
            chk("drop_err1", 32'(dec_err),   32'h0);
            if (dec_valid) xfers++;
            enc_codeword = 13'h0001;
            tick();
            chk("drop_v2", 32'(dec_valid), 32'h1);
            chk("drop_d2", 32'(dec_data),  32'h001);
            if (dec_valid) xfers++;
            enc_valid = 1'b0;
            tick();
            chk("drop_v3",    32'(dec_valid), 32'h0);
            chk("drop_xfers", 32'(xfers),     32'd2);
            chk("drop_cnt",   32'(err_count), 32'h1);
        end
`else
        // Clean back-to-back stream
        enc_valid = 1'b1; enc_codeword = 13'h1000;
        tick();
        chk("clean0_valid", 32'(dec_valid), 32'h1);
        chk("clean0_data",  32'(dec_data),  32'h000);
        chk("clean0_err",   32'(dec_err),   32'h0);
        enc_codeword = 13'h0001;
        tick();
        chk("clean1_data",  32'(dec_data),  32'h001);
        chk("clean1_valid", 32'(dec_valid), 32'h1);
        enc_codeword = 13'h1003;
        tick();
        chk("clean2_data",  32'(dec_data),  32'h003);
        chk("clean2_err",   32'(dec_err),   32'h0);
        enc_valid = 1'b0;
        tick();
        chk("drain_valid", 32'(dec_valid), 32'h0);
        chk("drain_hold",  32'(dec_data),  32'h003);
        chk("clean_count", 32'(err_count), 32'h0);

        // Single-bit errors
        enc_valid = 1'b1; enc_codeword = 13'h0000;
        tick();
        chk("e1_err",    32'(dec_err),    32'h1);
        chk("e1_data",   32'(dec_data),   32'h000);
        chk("e1_sticky", 32'(err_sticky), 32'h1);
        chk("e1_count",  32'(err_count),  32'h1);
        enc_codeword = 13'h1001;
        tick();
        chk("e2_err",   32'(dec_err),   32'h1);
        chk("e2_data",  32'(dec_data),  32'h001);
        chk("e2_count", 32'(err_count), 32'h2);
        enc_valid = 1'b0;
        tick();

        // Backpressure
        dec_ready = 1'b0;
        enc_valid = 1'b1; enc_codeword = 13'h0001;
        tick();
        chk("bp_valid", 32'(dec_valid), 32'h1);
        chk("bp_data",  32'(dec_data),  32'h001);
        chk("bp_err",   32'(dec_err),   32'h0);
        enc_codeword = 13'h1003;
        #1;
        chk("bp_ready", 32'(enc_ready), 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_hold_valid", 32'(dec_valid), 32'h1);
            chk("bp_hold_data",  32'(dec_data),  32'h001);
            chk("bp_hold_ready", 32'(enc_ready), 32'h0);
        end
        dec_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(enc_ready), 32'h1);
        tick();
        chk("bp_next_valid", 32'(dec_valid), 32'h1);
        chk("bp_next_data",  32'(dec_data),  32'h003);
        enc_valid = 1'b0;
        tick();
        chk("bp_drain_valid", 32'(dec_valid), 32'h0);
        chk("bp_count",       32'(err_count), 32'h2);

        // Saturation: count starts at 2, 260 more errors
        enc_valid = 1'b1; enc_codeword = 13'h0000;
        for (int i = 0; i < 252; i++) tick();
        chk("sat_fe", 32'(err_count), 32'hFE);
        tick();
        chk("sat_ff", 32'(err_count), 32'hFF);
        for (int i = 0; i < 7; i++) tick();
        chk("sat_hold",   32'(err_count),  32'hFF);
        chk("sat_sticky", 32'(err_sticky), 32'h1);

        // Clear wins over a coincident erroneous accept
        err_clr = 1'b1;
        tick();
        chk("clr_count",  32'(err_count),  32'h0);
        chk("clr_sticky", 32'(err_sticky), 32'h0);
        chk("clr_fwd",    32'(dec_err),    32'h1);
        err_clr = 1'b0;

        // X on the bus with enc_valid low leaves status untouched
        enc_valid = 1'b0; enc_codeword = 13'bx;
        tick();
        chk("x_count",  32'(err_count),  32'h0);
        chk("x_sticky", 32'(err_sticky), 32'h0);
        chk("x_valid",  32'(dec_valid),  32'h0);

        // Async reset in the middle of a stall
        dec_ready = 1'b0;
        enc_valid = 1'b1; enc_codeword = 13'h0003;
        tick();
        chk("ar_pre_valid", 32'(dec_valid), 32'h1);
        chk("ar_pre_data",  32'(dec_data),  32'h003);
        chk("ar_pre_err",   32'(dec_err),   32'h1);
        chk("ar_pre_count", 32'(err_count), 32'h1);
        #2 rst = 1'b0;
        #1;
        chk("ar_valid",  32'(dec_valid),  32'h0);
        chk("ar_data",   32'(dec_data),   32'h0);
        chk("ar_err",    32'(dec_err),    32'h0);
        chk("ar_sticky", 32'(err_sticky), 32'h0);
        chk("ar_count",  32'(err_count),  32'h0);
        enc_valid = 1'b0;
        dec_ready = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        enc_valid = 1'b1; enc_codeword = 13'h1003;
        tick();
        chk("post_valid", 32'(dec_valid), 32'h1);
        chk("post_data",  32'(dec_data),  32'h003);
        chk("post_err",   32'(dec_err),   32'h0);
        enc_valid = 1'b0;
        tick();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
